// File: rtl/mdio_master.sv
// MDIO (IEEE 802.3 clause 22) management master.
// Serialises one read or write frame per accepted command. MDC is derived
// from clk_rmii with a programmable half-period. Read data is sampled on the
// MDC rising edge and returned with a one-cycle completion pulse.
module mdio_master #(
  parameter int CLK_DIV      = 10,  // clk_rmii cycles per MDC half-period (2..255)
  parameter int PREAMBLE_LEN = 32   // leading '1' bits (0..32)
) (
  input  logic        clk_rmii,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, DONE} state_e;

  localparam int         NBITS    = PREAMBLE_LEN + 32;
  localparam logic [5:0] LAST_BIT = 6'(NBITS - 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Frame phase that owns bit k of the whole frame.
  function automatic state_e phase_of(input int k);
    int j;
    j = k - PREAMBLE_LEN;
    if (j < 0)  return PREAMBLE;
    if (j < 14) return HEADER;
    if (j < 16) return TA;
    return DATA;
  endfunction

  // A read frame releases the line from the first turnaround bit onwards.
  function automatic logic released(input logic rd, input int k);
    return rd && ((k - PREAMBLE_LEN) >= 14);
  endfunction

  // Value driven on MDIO for bit k; '1' while in preamble or released.
  function automatic logic frame_bit(input logic rd, input logic [4:0] phy,
                                     input logic [4:0] rg, input logic [15:0] wd,
                                     input int k);
    logic [31:0] f;
    int          j;
    j = k - PREAMBLE_LEN;
    if (j < 0 || released(rd, k)) return 1'b1;
    f = {2'b01, (rd ? 2'b10 : 2'b01), phy, rg, 2'b10, wd};
    f = f << j;
    return f[31];
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic        mdio_q, mdio_d;
  logic        mdt_q, mdt_d;
  logic        rd_q, rd_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] sh_q, sh_d;
  logic        err_sh_q, err_sh_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Next-state logic: command acceptance, MDC phase/bit sequencing and sampling.
  always_comb begin
    int cur_k;
    int nxt_k;
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    bit_d    = bit_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    mdio_d   = mdio_q;
    mdt_d    = mdt_q;
    rd_d     = rd_q;
    phy_d    = phy_q;
    reg_d    = reg_q;
    wd_d     = wd_q;
    sh_d     = sh_q;
    err_sh_d = err_sh_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cur_k    = int'(bit_q);
    nxt_k    = cur_k + 1;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_d    = cmd_read;
          phy_d   = cmd_phy_addr;
          reg_d   = cmd_reg_addr;
          wd_d    = cmd_wdata;
          bit_d   = '0;
          div_d   = '0;
          mdc_d   = 1'b0;
          state_d = phase_of(0);
          mdio_d  = frame_bit(cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata, 0);
          mdt_d   = released(cmd_read, 0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!mdc_q) begin
            // MDC rising edge: sample the PHY during the released part of a read.
            mdc_d = 1'b1;
            if (rd_q && (cur_k - PREAMBLE_LEN) == 15) err_sh_d = mdio_i;
            if (rd_q && (cur_k - PREAMBLE_LEN) >= 16) sh_d = {sh_q[14:0], mdio_i};
          end else begin
            mdc_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = DONE;
              mdio_d  = 1'b1;
              mdt_d   = 1'b1;
              if (rd_q) begin
                rdata_d = sh_q;
                err_d   = err_sh_q;
              end else begin
                err_d   = 1'b0;
              end
            end else begin
              bit_d   = bit_q + 6'd1;
              state_d = phase_of(nxt_k);
              mdio_d  = frame_bit(rd_q, phy_q, reg_q, wd_q, nxt_k);
              mdt_d   = released(rd_q, nxt_k);
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk_rmii or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      div_q    <= '0;
      mdc_q    <= 1'b0;
      mdio_q   <= 1'b1;
      mdt_q    <= 1'b1;
      rd_q     <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      sh_q     <= '0;
      err_sh_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      mdio_q   <= mdio_d;
      mdt_q    <= mdt_d;
      rd_q     <= rd_d;
      phy_q    <= phy_d;
      reg_q    <= reg_d;
      wd_q     <= wd_d;
      sh_q     <= sh_d;
      err_sh_q <= err_sh_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mdc_o     = mdc_q;
  assign mdio_o    = mdio_q;
  assign mdio_t    = mdt_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: two instances (CLK_DIV=2 with 32-bit and
// with no preamble) share command inputs and the MDIO input line.
module tb_mdio_master;

  logic        clk_rmii = 1'b0;
  logic        rst_ni   = 1'b0;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        v32 = 1'b0, v0 = 1'b0;

  logic        rdy32, rv32, er32, bz32, mdc32, mo32, mt32;
  logic        rdy0,  rv0,  er0,  bz0,  mdc0,  mo0,  mt0;
  logic [15:0] rd32, rd0;

  bit          sel = 1'b0;
  logic        s_ready, s_rv, s_err, s_busy, s_mdc, s_mo, s_mt;
  logic [15:0] s_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_rd [2];
  logic        exp_er [2];

  always #5 clk_rmii = ~clk_rmii;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut32 (
    .clk_rmii(clk_rmii), .rst_ni(rst_ni), .cmd_valid(v32), .cmd_ready(rdy32),
    .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(er32),
    .busy(bz32), .mdc_o(mdc32), .mdio_o(mo32), .mdio_t(mt32), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_dut0 (
    .clk_rmii(clk_rmii), .rst_ni(rst_ni), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0),
    .busy(bz0), .mdc_o(mdc0), .mdio_o(mo0), .mdio_t(mt0), .mdio_i(mdio_i)
  );

  assign s_ready = sel ? rdy0 : rdy32;
  assign s_rv    = sel ? rv0  : rv32;
  assign s_err   = sel ? er0  : er32;
  assign s_busy  = sel ? bz0  : bz32;
  assign s_mdc   = sel ? mdc0 : mdc32;
  assign s_mo    = sel ? mo0  : mo32;
  assign s_mt    = sel ? mt0  : mt32;
  assign s_rdata = sel ? rd0  : rd32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one complete frame on the selected instance, acting as the PHY and
  // checking MDC, MDIO and the handshake cycle by cycle against a frame model.
  // With hold set, cmd_valid stays high and the command fields are changed
  // mid-frame to a different command.
  task automatic run_frame(input string tag, input bit s, input logic rd,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic [15:0] phy_d,
                           input logic ta2, input bit hold, output logic [63:0] gotv);
    int          p, nb, lat, k, ph, j;
    int          e_mdc, e_t, e_stab, e_ctl;
    logic        prev_o;
    logic [31:0] f;
    logic [63:0] expv, mask;
    p      = s ? 0 : 32;
    nb     = p + 32;
    lat    = 1 + nb * 4;
    f      = {2'b01, (rd ? 2'b10 : 2'b01), phy, rg, 2'b10, wd};
    expv   = {32'hFFFF_FFFF, f};
    mask   = rd ? {32'hFFFF_FFFF, 14'h3FFF, 18'h0} : '1;
    gotv   = '1;
    e_mdc  = 0; e_t = 0; e_stab = 0; e_ctl = 0;
    prev_o = 1'b1;
    if (rd) begin
      exp_rd[s] = phy_d;
      exp_er[s] = ta2;
    end else begin
      exp_er[s] = 1'b0;
    end

    @(negedge clk_rmii);
    sel          = s;
    cmd_read     = rd;
    cmd_phy_addr = phy;
    cmd_reg_addr = rg;
    cmd_wdata    = wd;
    mdio_i       = 1'b1;
    if (s) v0 = 1'b1; else v32 = 1'b1;
    #1;
    check({tag, "_ready_idle"}, 64'(s_ready), 64'(1'b1));
    @(posedge clk_rmii);
    #1;
    if (hold) begin
      cmd_phy_addr = ~phy;
      cmd_reg_addr = ~rg;
      cmd_wdata    = ~wd;
    end else begin
      v0  = 1'b0;
      v32 = 1'b0;
    end

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk_rmii);
      if (c < lat) begin
        k  = (c - 1) / 4;
        ph = (c - 1) % 4;
        j  = k - p;
        if (s_mdc !== (ph >= 2)) e_mdc++;
        if (s_mt !== (rd && j >= 14)) e_t++;
        if (ph == 0) gotv[nb - 1 - k] = s_mo;
        else if (s_mo !== prev_o) e_stab++;
        prev_o = s_mo;
        if (s_busy !== 1'b1 || s_rv !== 1'b0 || s_ready !== 1'b0) e_ctl++;
        mdio_i = (rd && j == 15) ? ta2 : ((rd && j >= 16) ? phy_d[31 - j] : 1'b1);
      end else if (c == lat) begin
        mdio_i = 1'b1;
        check({tag, "_rsp_valid"}, 64'(s_rv), 64'(1'b1));
        check({tag, "_done_busy"}, 64'(s_busy), 64'(1'b1));
        check({tag, "_done_mdc"}, 64'(s_mdc), 64'(1'b0));
        check({tag, "_done_mdio_t"}, 64'(s_mt), 64'(1'b1));
        check({tag, "_rdata"}, 64'(s_rdata), 64'(exp_rd[s]));
        check({tag, "_err"}, 64'(s_err), 64'(exp_er[s]));
      end else begin
        check({tag, "_idle_valid"}, 64'(s_rv), 64'(1'b0));
        check({tag, "_idle_busy"}, 64'(s_busy), 64'(1'b0));
        check({tag, "_idle_ready"}, 64'(s_ready), 64'(1'b1));
      end
    end
    check({tag, "_frame"}, gotv & mask, expv & mask);
    check({tag, "_mdc_errs"}, 64'(e_mdc), 64'(0));
    check({tag, "_mdio_t_errs"}, 64'(e_t), 64'(0));
    check({tag, "_mdio_stable_errs"}, 64'(e_stab), 64'(0));
    check({tag, "_ctl_errs"}, 64'(e_ctl), 64'(0));
  endtask

  initial begin
    logic [63:0] g;
    int          n;
    int          seen;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_er[0] = 1'b0; exp_er[1] = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_rmii);
    check("rst_ready", 64'(rdy32), 64'(1'b1));
    check("rst_busy", 64'(bz32), 64'(1'b0));
    check("rst_valid", 64'(rv32), 64'(1'b0));
    check("rst_err", 64'(er32), 64'(1'b0));
    check("rst_rdata", 64'(rd32), 64'(16'h0000));
    check("rst_mdc", 64'(mdc32), 64'(1'b0));
    check("rst_mdio_o", 64'(mo32), 64'(1'b1));
    check("rst_mdio_t", 64'(mt32), 64'(1'b1));
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_rmii);

    // Write PHY 1 REG 0 data 0x1140: 32 ones then 0101 00001 00000 10 0x1140
    run_frame("wr1140", 1'b0, 1'b0, 5'd1, 5'd0, 16'h1140, 16'h0, 1'b0, 1'b0, g);
    check("wr1140_bits", g, {32'hFFFF_FFFF, 32'h5082_1140});

    // Read PHY 3 REG 2; PHY returns 0x0141 with a good turnaround
    run_frame("rd0141", 1'b0, 1'b1, 5'd3, 5'd2, 16'h0, 16'h0141, 1'b0, 1'b0, g);

    // Read with no PHY: line idles high
    run_frame("rd_nophy", 1'b0, 1'b1, 5'd7, 5'd1, 16'h0, 16'hFFFF, 1'b1, 1'b0, g);

    // Write on the instance without preamble; data must not touch rsp_rdata
    run_frame("p0_wr", 1'b1, 1'b0, 5'h1F, 5'h15, 16'hA5C3, 16'h0, 1'b0, 1'b0, g);
    check("p0_wr_bits", g[31:0], 64'({2'b01, 2'b01, 5'h1F, 5'h15, 2'b10, 16'hA5C3}));

    // cmd_valid held high across two commands; second accepted at cycle 258
    run_frame("hold_a", 1'b0, 1'b0, 5'h0A, 5'h11, 16'hBEEF, 16'h0, 1'b0, 1'b1, g);
    @(posedge clk_rmii);
    #1;
    v32 = 1'b0;
    n = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk_rmii);
      if (rv32) begin
        n = c;
        break;
      end
    end
    check("hold_b_latency", 64'(n), 64'(257));
    @(negedge clk_rmii);

    // Reset pulsed during bit 40 aborts the frame
    @(negedge clk_rmii);
    sel = 1'b0; cmd_read = 1'b0; cmd_phy_addr = 5'd5; cmd_reg_addr = 5'd9;
    cmd_wdata = 16'h1234; v32 = 1'b1;
    @(posedge clk_rmii);
    #1;
    v32 = 1'b0;
    for (int c = 1; c <= 163; c++) @(negedge clk_rmii);
    check("abort_pre_mdc", 64'(mdc32), 64'(1'b1));
    rst_ni = 1'b0;
    #1;
    check("abort_mdc", 64'(mdc32), 64'(1'b0));
    check("abort_mdio_t", 64'(mt32), 64'(1'b1));
    check("abort_busy", 64'(bz32), 64'(1'b0));
    check("abort_valid", 64'(rv32), 64'(1'b0));
    check("abort_rdata", 64'(rd32), 64'(16'h0000));
    check("abort_err", 64'(er32), 64'(1'b0));
    @(negedge clk_rmii);
    rst_ni = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_rmii);
      if (rv32 || bz32) seen++;
    end
    check("abort_no_rsp", 64'(seen), 64'(0));

    // Normal command after the abort
    run_frame("post_abort_wr", 1'b0, 1'b0, 5'd2, 5'd4, 16'h0F0F, 16'h0, 1'b0, 1'b0, g);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
